regfile_wb_scheduler: RTL and testbench

//   Shares the single register-file write port between NUM_REQ writeback requesters
//   (e.g. ALU, load unit) using round-robin arbitration with a valid/ready handshake.

---
 rtl/regfile_wb_scheduler_pkg.sv | 19 +
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 47 ++++
 rtl/regfile_wb_scheduler.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler_pkg
//   Shared constants for the register-file writeback scheduler.
//   - DEFAULT_AW / DEFAULT_DW : default register index and data widths
//   - REG_ZERO                : index of the hardwired-zero register
//   - wrap_inc()              : modulo-n increment used for round-robin pointers
// -----------------------------------------------------------------------------
package regfile_wb_scheduler_pkg;

   localparam int DEFAULT_AW = 5;
   localparam int DEFAULT_DW = 32;
   localparam int REG_ZERO   = 0;

   // Next index after idx in a ring of n entries.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. Searches req starting at ptr,
//   then ptr+1, ... modulo N, and grants the first requester found.
//   Ports:
//     req    in  N   request vector
//     ptr    in  PW  highest-priority index this cycle (must be < N)
//     grant  out N   one-hot grant, zero when no request
//     winner out PW  index of the granted requester (0 when none)
//     any    out 1   at least one request present (a grant is issued)
// -----------------------------------------------------------------------------
module rr_arbiter
   import regfile_wb_scheduler_pkg::*;
#(
   parameter  int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] winner,
   output logic          any
);

   int idx;

   // The grant depends only on req and ptr, never on any downstream ready,
   // so there is no combinational loop through the handshake.
   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            winner     = PW'(idx);
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
//   Shares the single register-file write port between NUM_REQ writeback
//   requesters using round-robin arbitration, keeps a per-register
//   pending-write scoreboard and raises a combinational hazard stall for the
//   issue stage (RAW on rs1/rs2, WAW on rd).
//
//   Ports:
//     clk, rst_n      clock (posedge) and asynchronous active-low reset
//     issue_valid     issue stage presents an instruction
//     issue_rs1/rs2   source register indices
//     issue_rd        destination register index
//     issue_writes    instruction writes issue_rd
//     issue_stall     combinational: instruction must not issue this cycle
//     wb_valid        per-requester writeback request
//     wb_rd           packed destinations, requester i at [i*AW +: AW]
//     wb_data         packed data, requester i at [i*DW +: DW]
//     wb_ready        one-hot combinational grant
//     rf_reg_write    registered write enable toward the register file
//     rf_rd           registered write index
//     rf_write_data   registered write data
//     wb_unexpected   sticky flag: writeback to a non-pending nonzero register
//
//   Handshake: a requester raises wb_valid[i] with wb_rd/wb_data and holds
//   all three stable until it sees wb_ready[i]; the transfer happens at the
//   posedge where wb_valid[i] & wb_ready[i]. wb_ready is computed from
//   wb_valid and the round-robin pointer only. An rd of zero is still granted
//   and consumed, but produces no register write.
// -----------------------------------------------------------------------------
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = DEFAULT_DW,
   parameter int ADDR_WIDTH = DEFAULT_AW
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          issue_valid,
   input  logic [ADDR_WIDTH-1:0]         issue_rs1,
   input  logic [ADDR_WIDTH-1:0]         issue_rs2,
   input  logic [ADDR_WIDTH-1:0]         issue_rd,
   input  logic                          issue_writes,
   output logic                          issue_stall,
   input  logic [NUM_REQ-1:0]            wb_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] wb_rd,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wb_data,
   output logic [NUM_REQ-1:0]            wb_ready,
   output logic                          rf_reg_write,
   output logic [ADDR_WIDTH-1:0]         rf_rd,
   output logic [DATA_WIDTH-1:0]         rf_write_data,
   output logic                          wb_unexpected
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam int PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   // Pending-write scoreboard, one bit per architectural register.
   logic [NUM_REGS-1:0]   sb;
   logic [NUM_REGS-1:0]   sb_next;
   logic                  sb_set;

   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         rr_ptr_next;
   logic [PW-1:0]         winner;
   logic                  xfer;

   logic [ADDR_WIDTH-1:0] win_rd;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  win_unexpected;

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   assign issue_stall = issue_valid &
                        (sb[issue_rs1] | sb[issue_rs2] | (issue_writes & sb[issue_rd]));

   assign sb_set = issue_valid & issue_writes & ~issue_stall & (issue_rd != ZERO_IDX);

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req    (wb_valid),
      .ptr    (rr_ptr),
      .grant  (wb_ready),
      .winner (winner),
      .any    (xfer)
   );

   // The grant is one-hot, so an OR-select over the granted lane picks the
   // winner's payload without a variable part-select.
   always_comb begin
      win_rd   = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wb_ready[i]) begin
            win_rd   = wb_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_data = wb_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign rr_ptr_next    = PW'(wrap_inc(int'(winner), NUM_REQ));

   // Looked up in the scoreboard as it stands before this edge's update.
   assign win_unexpected = (win_rd != ZERO_IDX) & ~sb[win_rd];

   // ---------------------------------------------------------------------------
   // Scoreboard next state
   //   The clear comes from the registered write that is in flight this cycle,
   //   so a register stays busy through its write cycle. A new producer issued
   //   on the same edge wins over the clear, hence the set is applied last.
   // ---------------------------------------------------------------------------
   always_comb begin
      sb_next = sb;
      if (rf_reg_write) begin
         sb_next[rf_rd] = 1'b0;
      end
      if (sb_set) begin
         sb_next[issue_rd] = 1'b1;
      end
      sb_next[REG_ZERO] = 1'b0;
   end

   // ---------------------------------------------------------------------------
   // State: scoreboard, round-robin pointer, output register, sticky flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb            <= '0;
         rr_ptr        <= '0;
         rf_reg_write  <= 1'b0;
         rf_rd         <= '0;
         rf_write_data <= '0;
         wb_unexpected <= 1'b0;
      end else begin
         sb <= sb_next;
         if (xfer) begin
            rr_ptr        <= rr_ptr_next;
            rf_rd         <= win_rd;
            rf_write_data <= win_data;
            rf_reg_write  <= (win_rd != ZERO_IDX);
            if (win_unexpected) begin
               wb_unexpected <= 1'b1;
            end
         end else begin
            // Index and data hold so the register file sees stable values.
            rf_reg_write <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

   localparam int NR = 2;
   localparam int AW = 5;
   localparam int DW = 32;

   // ---------------------------------------------------------------------------
   // DUT signals
   // ---------------------------------------------------------------------------
   logic             clk;
   logic             rst_n;
   logic             issue_valid;
   logic [AW-1:0]    issue_rs1;
   logic [AW-1:0]    issue_rs2;
   logic [AW-1:0]    issue_rd;
   logic             issue_writes;
   logic             issue_stall;
   logic [NR-1:0]    wb_valid;
   logic [NR*AW-1:0] wb_rd;
   logic [NR*DW-1:0] wb_data;
   logic [NR-1:0]    wb_ready;
   logic             rf_reg_write;
   logic [AW-1:0]    rf_rd;
   logic [DW-1:0]    rf_write_data;
   logic             wb_unexpected;

   int checks = 0;
   int errors = 0;

   // Expected register-file writes {rd, data}, oldest first.
   logic [AW+DW-1:0] exp_q[$];

   regfile_wb_scheduler #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid   (issue_valid),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_rd      (issue_rd),
      .issue_writes  (issue_writes),
      .issue_stall   (issue_stall),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .wb_ready      (wb_ready),
      .rf_reg_write  (rf_reg_write),
      .rf_rd         (rf_rd),
      .rf_write_data (rf_write_data),
      .wb_unexpected (wb_unexpected)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic iw, input logic [NR-1:0] wv,
                        input logic [AW-1:0] rd0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] rd1, input logic [DW-1:0] d1);
      issue_valid  = iv;
      issue_rs1    = rs1;
      issue_rs2    = rs2;
      issue_rd     = rd;
      issue_writes = iw;
      wb_valid     = wv;
      wb_rd        = {rd1, rd0};
      wb_data      = {d1, d0};
   endtask

   task automatic drive_idle();
      drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
   endtask

   // Reset is applied away from the active edge and released on a negedge.
   task automatic do_reset();
      @(negedge clk);
      drive_idle();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table: one row per cycle. Stall/ready are checked before
   // the edge, registered outputs one time unit after it.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic          iv;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rd;
      logic          iw;
      logic [NR-1:0] wv;
      logic [AW-1:0] rd0;
      logic [DW-1:0] d0;
      logic [AW-1:0] rd1;
      logic [DW-1:0] d1;
      logic          x_stall;
      logic [NR-1:0] x_ready;
      logic          x_we;
      logic [AW-1:0] x_rd;
      logic [DW-1:0] x_data;
      logic          x_unexp;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic iv, logic [AW-1:0] rs1, logic [AW-1:0] rs2,
                               logic [AW-1:0] rd, logic iw, logic [NR-1:0] wv,
                               logic [AW-1:0] rd0, logic [DW-1:0] d0,
                               logic [AW-1:0] rd1, logic [DW-1:0] d1,
                               logic x_stall, logic [NR-1:0] x_ready, logic x_we,
                               logic [AW-1:0] x_rd, logic [DW-1:0] x_data, logic x_unexp);
      vec_t v;
      v.iv = iv;   v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.iw = iw;
      v.wv = wv;   v.rd0 = rd0; v.d0 = d0;   v.rd1 = rd1; v.d1 = d1;
      v.x_stall = x_stall; v.x_ready = x_ready; v.x_we = x_we;
      v.x_rd = x_rd; v.x_data = x_data; v.x_unexp = x_unexp;
      return v;
   endfunction

   task automatic fill_vecs();
      //            iv  rs1 rs2 rd iw  wv     rd0 d0            rd1 d1          stall ready  we rd data          unexp
      vecs[0]  = mk(1, 0, 0, 5, 1, 2'b00, 0, 32'h0,        0, 32'h0,      0, 2'b00, 0, 0, 32'h0,        0);
      vecs[1]  = mk(1, 5, 0, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,      1, 2'b00, 0, 0, 32'h0,        0);
      vecs[2]  = mk(1, 5, 0, 0, 0, 2'b01, 5, 32'hDEADBEEF, 0, 32'h0,      1, 2'b01, 1, 5, 32'hDEADBEEF, 0);
      vecs[3]  = mk(1, 5, 0, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,      1, 2'b00, 0, 5, 32'hDEADBEEF, 0);
      vecs[4]  = mk(1, 5, 0, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,      0, 2'b00, 0, 5, 32'hDEADBEEF, 0);
      vecs[5]  = mk(1, 0, 0, 3, 1, 2'b00, 0, 32'h0,        0, 32'h0,      0, 2'b00, 0, 5, 32'hDEADBEEF, 0);
      vecs[6]  = mk(1, 0, 0, 4, 1, 2'b00, 0, 32'h0,        0, 32'h0,      0, 2'b00, 0, 5, 32'hDEADBEEF, 0);
      vecs[7]  = mk(0, 0, 0, 0, 0, 2'b11, 3, 32'h33,       4, 32'h44,     0, 2'b10, 1, 4, 32'h44,       0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 2'b11, 3, 32'h33,       0, 32'h1234,   0, 2'b01, 1, 3, 32'h33,       0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 2'b10, 0, 32'h0,        0, 32'h1234,   0, 2'b10, 0, 0, 32'h1234,     0);
      vecs[10] = mk(0, 0, 0, 0, 0, 2'b01, 7, 32'h77,       0, 32'h0,      0, 2'b01, 1, 7, 32'h77,       1);
      vecs[11] = mk(1, 0, 0, 7, 1, 2'b00, 0, 32'h0,        0, 32'h0,      0, 2'b00, 0, 7, 32'h77,       1);
      vecs[12] = mk(1, 0, 7, 0, 0, 2'b00, 0, 32'h0,        0, 32'h0,      1, 2'b00, 0, 7, 32'h77,       1);
      vecs[13] = mk(1, 0, 0, 7, 1, 2'b00, 0, 32'h0,        0, 32'h0,      1, 2'b00, 0, 7, 32'h77,       1);
      vecs[14] = mk(0, 7, 7, 7, 1, 2'b00, 0, 32'h0,        0, 32'h0,      0, 2'b00, 0, 7, 32'h77,       1);
      vecs[15] = mk(1, 0, 0, 0, 1, 2'b00, 0, 32'h0,        0, 32'h0,      0, 2'b00, 0, 7, 32'h77,       1);
   endtask

   task automatic run_table();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].iw,
               vecs[i].wv, vecs[i].rd0, vecs[i].d0, vecs[i].rd1, vecs[i].d1);
         #1;
         check($sformatf("vec%0d_stall", i), 64'(issue_stall), 64'(vecs[i].x_stall));
         check($sformatf("vec%0d_ready", i), 64'(wb_ready), 64'(vecs[i].x_ready));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_we", i), 64'(rf_reg_write), 64'(vecs[i].x_we));
         check($sformatf("vec%0d_rd", i), 64'(rf_rd), 64'(vecs[i].x_rd));
         check($sformatf("vec%0d_data", i), 64'(rf_write_data), 64'(vecs[i].x_data));
         check($sformatf("vec%0d_unexp", i), 64'(wb_unexpected), 64'(vecs[i].x_unexp));
      end
   endtask

   // ---------------------------------------------------------------------------
   // Hand-written sequences
   // ---------------------------------------------------------------------------
   // Reset asserted while a write is on the port and wb_unexpected is set.
   task automatic seq_async_reset();
      @(negedge clk);
      drive(1'b1, '0, '0, 5'd5, 1'b1, 2'b00, '0, '0, '0, '0);
      @(negedge clk);
      drive(1'b0, '0, '0, '0, 1'b0, 2'b11, 5'd5, 32'hAAAA, 5'd7, 32'hBBBB);
      @(posedge clk);
      #1;
      check("burst_we", 64'(rf_reg_write), 64'd1);
      check("burst_rd", 64'(rf_rd), 64'd7);
      check("burst_data", 64'(rf_write_data), 64'hBBBB);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_we", 64'(rf_reg_write), 64'd0);
      check("arst_rd", 64'(rf_rd), 64'd0);
      check("arst_data", 64'(rf_write_data), 64'd0);
      check("arst_unexp", 64'(wb_unexpected), 64'd0);
      issue_valid  = 1'b1;
      issue_rs1    = 5'd5;
      issue_rs2    = 5'd7;
      issue_rd     = 5'd5;
      issue_writes = 1'b1;
      #1;
      check("arst_stall", 64'(issue_stall), 64'd0);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Writeback to a register nobody is waiting on: write still happens,
   // flag sets and sticks until reset.
   task automatic seq_unexpected();
      @(negedge clk);
      drive(1'b0, '0, '0, '0, 1'b0, 2'b01, 5'd9, 32'h99, '0, '0);
      #1;
      check("unx_ready", 64'(wb_ready), 64'b01);
      @(posedge clk);
      #1;
      check("unx_we", 64'(rf_reg_write), 64'd1);
      check("unx_rd", 64'(rf_rd), 64'd9);
      check("unx_flag", 64'(wb_unexpected), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_idle();
         @(posedge clk);
         #1;
         check($sformatf("unx_sticky%0d", i), 64'(wb_unexpected), 64'd1);
      end
      do_reset();
      #1;
      check("unx_cleared", 64'(wb_unexpected), 64'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Randomized phase against a reference model.
   //   busy        : registers with an outstanding producer
   //   wr_pending  : the write currently on the register-file port
   // ---------------------------------------------------------------------------
   task automatic run_random(input int n_cycles);
      bit [31:0]     busy;
      bit [31:0]     busy_next;
      int            ptr;
      bit            unexp;
      bit            wr_pending;
      logic [AW-1:0] wr_rd;
      logic [DW-1:0] wr_data;
      bit            rq_v[NR];
      logic [AW-1:0] rq_rd[NR];
      logic [DW-1:0] rq_d[NR];
      logic          iv;
      logic          iw;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rd;
      logic          e_stall;
      logic [NR-1:0] e_ready;
      int            w;
      int            pick[$];
      logic [AW+DW-1:0] got;

      busy = '0; ptr = 0; unexp = 0; wr_pending = 0; wr_rd = '0; wr_data = '0;
      for (int i = 0; i < NR; i++) begin
         rq_v[i] = 0; rq_rd[i] = '0; rq_d[i] = '0;
      end

      for (int c = 0; c < n_cycles; c++) begin
         @(negedge clk);
         // Requesters: new request only when idle; mostly to registers that
         // are actually pending, occasionally anywhere (including r0).
         for (int i = 0; i < NR; i++) begin
            if (!rq_v[i] && $urandom_range(0, 99) < 60) begin
               pick.delete();
               for (int r = 1; r < 32; r++) begin
                  if (busy[r]) pick.push_back(r);
               end
               rq_v[i] = 1;
               if (pick.size() > 0 && $urandom_range(0, 9) != 0)
                  rq_rd[i] = AW'(pick[$urandom_range(0, pick.size() - 1)]);
               else
                  rq_rd[i] = AW'($urandom_range(0, 31));
               rq_d[i] = $urandom;
            end
         end
         iv  = ($urandom_range(0, 3) != 0);
         iw  = $urandom_range(0, 1);
         rs1 = AW'($urandom_range(0, 31));
         rs2 = AW'($urandom_range(0, 31));
         rd  = AW'($urandom_range(0, 31));
         drive(iv, rs1, rs2, rd, iw, {rq_v[1], rq_v[0]},
               rq_rd[0], rq_d[0], rq_rd[1], rq_d[1]);

         // A register is a hazard if it has any outstanding producer.
         e_stall = iv && (busy[rs1] || busy[rs2] || (iw && busy[rd]));
         w = -1;
         for (int k = 0; k < NR; k++) begin
            if (w < 0 && rq_v[(ptr + k) % NR]) w = (ptr + k) % NR;
         end
         e_ready = (w >= 0) ? NR'(1 << w) : '0;
         #1;
         check("rnd_stall", 64'(issue_stall), 64'(e_stall));
         check("rnd_ready", 64'(wb_ready), 64'(e_ready));

         // What the coming edge does: retire the in-flight write, record a
         // new producer (which wins), accept the granted writeback.
         busy_next = busy;
         if (wr_pending) busy_next[wr_rd] = 1'b0;
         if (iv && iw && !e_stall && rd != 0) busy_next[rd] = 1'b1;
         if (w >= 0) begin
            if (rq_rd[w] != 0 && !busy[rq_rd[w]]) unexp = 1;
            wr_pending = (rq_rd[w] != 0);
            wr_rd      = rq_rd[w];
            wr_data    = rq_d[w];
            ptr        = (w + 1) % NR;
            if (wr_pending) exp_q.push_back({wr_rd, wr_data});
         end else begin
            wr_pending = 0;
         end
         busy = busy_next;

         @(posedge clk);
         #1;
         if (w >= 0) rq_v[w] = 0;
         check("rnd_we", 64'(rf_reg_write), 64'(wr_pending));
         check("rnd_rd", 64'(rf_rd), 64'(wr_rd));
         check("rnd_data", 64'(rf_write_data), 64'(wr_data));
         check("rnd_unexp", 64'(wb_unexpected), 64'(unexp));
         if (rf_reg_write) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rnd_sb_extra: write rd=%0d data=%0h with nothing expected",
                        rf_rd, rf_write_data);
            end else begin
               got = exp_q.pop_front();
               check("rnd_sb_write", 64'({rf_rd, rf_write_data}), 64'(got));
            end
         end
      end
      check("rnd_sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      rst_n = 1'b0;
      drive_idle();
      fill_vecs();
      #12;
      check("rst_we", 64'(rf_reg_write), 64'd0);
      check("rst_rd", 64'(rf_rd), 64'd0);
      check("rst_data", 64'(rf_write_data), 64'd0);
      check("rst_unexp", 64'(wb_unexpected), 64'd0);
      check("rst_ready", 64'(wb_ready), 64'd0);
      issue_valid = 1'b1;
      issue_rs1   = 5'd5;
      issue_rs2   = 5'd31;
      #1;
      check("rst_stall", 64'(issue_stall), 64'd0);
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;

      run_table();
      seq_async_reset();
      seq_unexpected();
      do_reset();
      run_random(600);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
